if_id_queue: RTL and testbench



---
 rtl/if_id_queue_if.sv | 27 ++
 rtl/if_id_queue.sv | 86 ++++++++
 tb/tb_if_id_queue.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The master side is the pipeline environment (fetch, decode, flush source);
// the slave side is the queue itself.
interface if_id_queue_if #(
  parameter int PTRW = 1
);
  logic            flush;
  logic            ifValid;
  logic [31:0]     ifPCadded;
  logic [31:0]     ifInstruction;
  logic            PCLd;
  logic            idReady;
  logic            idValid;
  logic [31:0]     idPCadded;
  logic [31:0]     idInstruction;
  logic [PTRW:0]   count;

  modport master (
    output flush, ifValid, ifPCadded, ifInstruction, idReady,
    input  PCLd, idValid, idPCadded, idInstruction, count
  );

  modport slave (
    input  flush, ifValid, ifPCadded, ifInstruction, idReady,
    output PCLd, idValid, idPCadded, idInstruction, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: a small circular buffer of {PC+4, instruction}
// pairs between fetch and decode. Fetch is throttled through PCLd when the
// buffer is full, a flush drops every queued entry, and decode sees a NOP
// (all zeros) whenever nothing is queued.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int PTRW  = 1
) (
  input  logic         clk,
  input  logic         rst,
  if_id_queue_if.slave q
);

  localparam logic [PTRW:0] FULL_COUNT = (PTRW + 1)'(DEPTH);

  logic [63:0]     mem_q [DEPTH];
  logic [63:0]     mem_d [DEPTH];
  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [PTRW:0]   count_q, count_d;

  logic full;
  logic empty;
  logic enq;
  logic deq;

  // Status and handshake qualifiers, all derived from registered occupancy so
  // PCLd never depends combinationally on idReady; flush vetoes both moves.
  always_comb begin
    full  = (count_q == FULL_COUNT);
    empty = (count_q == '0);
    enq   = q.ifValid & ~full & ~q.flush;
    deq   = ~empty & q.idReady & ~q.flush;
  end

  assign q.PCLd          = ~full;
  assign q.idValid       = ~empty;
  assign q.idPCadded     = empty ? 32'b0 : mem_q[head_q][63:32];
  assign q.idInstruction = empty ? 32'b0 : mem_q[head_q][31:0];
  assign q.count         = count_q;

  // Next-state for storage, pointers and occupancy; a full queue never enqueues
  // and an empty one never dequeues, so count stays within 0..DEPTH.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        mem_d[tail_q] = {q.ifPCadded, q.ifInstruction};
        tail_d        = tail_q + PTRW'(1);
      end
      if (deq) begin
        head_d = head_q + PTRW'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + (PTRW + 1)'(1);
      end else if (deq && !enq) begin
        count_d = count_q - (PTRW + 1)'(1);
      end
    end
  end

  // State registers; reset clears storage too so the NOP is guaranteed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH = 2). Stimulus pushes every pair it
// expects to be accepted into a scoreboard; a negedge monitor pops and checks
// each pair as decode consumes it. Status outputs are checked against
// hand-computed values after each cycle.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int PTRW  = 1;

  logic clk;
  logic rst;

  int errorCount = 0;
  int checkCount = 0;
  int modelCount = 0;
  logic [63:0] sbQueue[$];

  if_id_queue_if #(.PTRW(PTRW)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus.slave)
  );

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Checks all status outputs against hand-computed values.
  task automatic checkOutput(input string name, input int expCount, input bit expValid,
                             input bit expPCLd, input logic [31:0] expPC,
                             input logic [31:0] expInstr);
    compareValue({name, ".count"}, 32'(bus.count), 32'(expCount));
    compareValue({name, ".idValid"}, 32'(bus.idValid), 32'(expValid));
    compareValue({name, ".PCLd"}, 32'(bus.PCLd), 32'(expPCLd));
    compareValue({name, ".idPCadded"}, bus.idPCadded, expPC);
    compareValue({name, ".idInstruction"}, bus.idInstruction, expInstr);
  endtask

  // Drives one cycle of inputs just after a rising edge, records accepted
  // pairs in the scoreboard, then waits until just after the next edge.
  task automatic applyStimulus(input bit valid, input logic [31:0] pc, input logic [31:0] instr,
                               input bit ready, input bit fl);
    bit enq;
    bit deq;
    bus.ifValid       = valid;
    bus.ifPCadded     = pc;
    bus.ifInstruction = instr;
    bus.idReady       = ready;
    bus.flush         = fl;
    enq = valid && (modelCount != DEPTH) && !fl;
    deq = ready && (modelCount != 0) && !fl;
    if (fl) begin
      sbQueue.delete();
      modelCount = 0;
    end else begin
      if (enq) sbQueue.push_back({pc, instr});
      modelCount = modelCount + (enq ? 1 : 0) - (deq ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: whenever decode will consume the head on the next edge, the head
  // must be the oldest pair still in the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.idValid && bus.idReady && !bus.flush) begin
      checkCount++;
      if (sbQueue.size() == 0) begin
        errorCount++;
        $display("[TB] FAIL monitor.unexpected: got %h expected no entry",
                 {bus.idPCadded, bus.idInstruction});
      end else begin
        logic [63:0] expPair;
        expPair = sbQueue.pop_front();
        if ({bus.idPCadded, bus.idInstruction} !== expPair) begin
          errorCount++;
          $display("[TB] FAIL monitor.pair: got %h expected %h",
                   {bus.idPCadded, bus.idInstruction}, expPair);
        end
      end
    end
  end

  initial begin
    rst               = 1'b1;
    bus.flush         = 1'b0;
    bus.ifValid       = 1'b0;
    bus.ifPCadded     = '0;
    bus.ifInstruction = '0;
    bus.idReady       = 1'b0;
    #3;
    checkOutput("reset", 0, 0, 1, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset in the middle of operation.
    applyStimulus(1, 32'd4, 32'h8C220004, 0, 0);
    checkOutput("midrst.pre", 1, 1, 1, 32'd4, 32'h8C220004);
    bus.ifValid = 1'b0;
    #2;
    rst = 1'b1;
    sbQueue.delete();
    modelCount = 0;
    #1;
    checkOutput("midrst.async", 0, 0, 1, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill to full with decode stalled; the third pair is refused.
    applyStimulus(1, 32'd4, 32'h8C220004, 0, 0);
    checkOutput("fill.1", 1, 1, 1, 32'd4, 32'h8C220004);
    applyStimulus(1, 32'd8, 32'h00221820, 0, 0);
    checkOutput("fill.2", 2, 1, 0, 32'd4, 32'h8C220004);
    applyStimulus(1, 32'd12, 32'hAC230008, 0, 0);
    checkOutput("fill.refuse", 2, 1, 0, 32'd4, 32'h8C220004);

    // Full with idReady: dequeue only, PCLd returns next cycle.
    applyStimulus(1, 32'd12, 32'hAC230008, 1, 0);
    checkOutput("full.deq", 1, 1, 1, 32'd8, 32'h00221820);
    applyStimulus(1, 32'd16, 32'h8C240010, 0, 0);
    checkOutput("refill.wrap", 2, 1, 0, 32'd8, 32'h00221820);

    // Flush at count 2 with concurrent fetch and decode activity.
    applyStimulus(1, 32'h100, 32'hDEADBEEF, 1, 1);
    checkOutput("flush", 0, 0, 1, 32'h0, 32'h0);

    // Empty with idReady for three cycles, then a single enqueue.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 32'h0, 32'h0, 1, 0);
      checkOutput("empty.ready", 0, 0, 1, 32'h0, 32'h0);
    end
    applyStimulus(1, 32'h40, 32'h20420001, 1, 0);
    checkOutput("empty.enq", 1, 1, 1, 32'h40, 32'h20420001);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    checkOutput("empty.drain", 0, 0, 1, 32'h0, 32'h0);

    // Simultaneous enqueue and dequeue at count 1.
    applyStimulus(1, 32'h50, 32'h00000011, 0, 0);
    checkOutput("simul.pre", 1, 1, 1, 32'h50, 32'h00000011);
    applyStimulus(1, 32'h54, 32'h00000022, 1, 0);
    checkOutput("simul.both", 1, 1, 1, 32'h54, 32'h00000022);
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    checkOutput("simul.drain", 0, 0, 1, 32'h0, 32'h0);

    // Streaming six pairs with decode always ready; pointers wrap repeatedly.
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(1, 32'(4 * i), 32'h20000000 | 32'(i), 1, 0);
      checkOutput("stream", 1, 1, 1, 32'(4 * i), 32'h20000000 | 32'(i));
    end
    applyStimulus(0, 32'h0, 32'h0, 1, 0);
    checkOutput("stream.drain", 0, 0, 1, 32'h0, 32'h0);

    compareValue("scoreboard.leftover", 32'(sbQueue.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
